// File: rtl/conv_row_scheduler.sv
// Row-level sequencer for one PE's read address generator: accepts a job descriptor,
// starts the generator, gates psum_done against downstream backpressure and frees IF entries.
module conv_row_scheduler #(
   parameter int IF_ADDR_LEN      = 8,
   parameter int FILT_ADDR_LEN    = 8,
   parameter int IF_SCRATCH_DEPTH = 8,
   parameter int WIN_W            = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [IF_ADDR_LEN-1:0]   cfg_stride,
   input  logic [FILT_ADDR_LEN-1:0] cfg_filter_len,
   input  logic [IF_ADDR_LEN-1:0]   cfg_if_len,
   input  logic                     sw_abort,
   output logic                     agen_start,
   output logic                     agen_reset_filter,
   output logic                     agen_usage_stride_pos_ld,
   output logic [IF_ADDR_LEN-1:0]   agen_stride_len,
   output logic [FILT_ADDR_LEN-1:0] agen_filter_len,
   output logic [IF_ADDR_LEN-1:0]   agen_if_start_pos,
   input  logic                     agen_done,
   input  logic                     agen_full_done,
   input  logic                     mac_psum_done,
   output logic                     agen_psum_done,
   output logic                     agen_stall,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIN_W-1:0]         out_win_idx,
   output logic                     if_release,
   output logic [IF_ADDR_LEN-1:0]   if_release_cnt,
   output logic                     job_done,
   output logic [WIN_W-1:0]         job_windows
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_RUN,
      S_DRAIN,
      S_RELEASE
   } state_e;

   localparam logic [IF_ADDR_LEN:0] DEPTH = (IF_ADDR_LEN+1)'(IF_SCRATCH_DEPTH);

   state_e                   state_q;
   logic [IF_ADDR_LEN-1:0]   if_len_q;
   logic [WIN_W-1:0]         win_cnt_q;
   logic                     start_q;
   logic                     reset_filter_q;
   logic                     usage_ld_q;
   logic [IF_ADDR_LEN-1:0]   stride_q;
   logic [FILT_ADDR_LEN-1:0] filter_len_q;
   logic [IF_ADDR_LEN-1:0]   ptr_q;
   logic [IF_ADDR_LEN-1:0]   ptr_d;
   logic                     out_valid_q;
   logic [WIN_W-1:0]         out_win_idx_q;
   logic                     release_q;
   logic [IF_ADDR_LEN-1:0]   release_cnt_q;
   logic                     job_done_q;
   logic [WIN_W-1:0]         job_windows_q;

   logic                     in_run;
   logic                     out_blocked;
   logic                     win_event;
   logic [IF_ADDR_LEN:0]     ptr_sum;
   logic [IF_ADDR_LEN:0]     ptr_wrap;

   assign in_run         = (state_q == S_RUN);
   assign out_blocked    = out_valid_q & ~out_ready;
   assign agen_stall     = in_run & out_blocked;
   assign agen_psum_done = in_run & mac_psum_done & ~out_blocked;
   assign win_event      = agen_done & agen_psum_done;
   assign cfg_ready      = (state_q == S_IDLE);

   // Extra bit keeps pointer + length from overflowing before the modulo.
   assign ptr_sum  = {1'b0, ptr_q} + {1'b0, if_len_q};
   assign ptr_wrap = ptr_sum % DEPTH;
   assign ptr_d    = ptr_wrap[IF_ADDR_LEN-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         if_len_q       <= '0;
         win_cnt_q      <= '0;
         start_q        <= 1'b0;
         reset_filter_q <= 1'b0;
         usage_ld_q     <= 1'b0;
         stride_q       <= '0;
         filter_len_q   <= '0;
         ptr_q          <= '0;
         out_valid_q    <= 1'b0;
         out_win_idx_q  <= '0;
         release_q      <= 1'b0;
         release_cnt_q  <= '0;
         job_done_q     <= 1'b0;
         job_windows_q  <= '0;
      end else begin
         // NOTE: pulses default low here; later non-blocking assignments in this block override them.
         start_q        <= 1'b0;
         reset_filter_q <= 1'b0;
         release_q      <= 1'b0;
         job_done_q     <= 1'b0;

         if (out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (win_event) begin
            out_valid_q   <= 1'b1;
            out_win_idx_q <= win_cnt_q;
            win_cnt_q     <= win_cnt_q + WIN_W'(1);
         end

         if (sw_abort && state_q != S_IDLE) begin
            state_q        <= S_IDLE;
            reset_filter_q <= 1'b1;
            usage_ld_q     <= 1'b0;
            out_valid_q    <= 1'b0;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (cfg_valid) begin
                     stride_q       <= cfg_stride;
                     filter_len_q   <= cfg_filter_len;
                     if_len_q       <= cfg_if_len;
                     win_cnt_q      <= '0;
                     start_q        <= 1'b1;
                     reset_filter_q <= 1'b1;
                     state_q        <= S_START;
                  end
               end
               S_START: begin
                  usage_ld_q <= 1'b1;
                  state_q    <= S_RUN;
               end
               S_RUN: begin
                  if (agen_full_done) begin
                     usage_ld_q <= 1'b0;
                     state_q    <= S_DRAIN;
                  end
               end
               S_DRAIN: begin
                  if (!out_valid_q) begin
                     state_q <= S_RELEASE;
                  end
               end
               S_RELEASE: begin
                  job_done_q    <= 1'b1;
                  job_windows_q <= win_cnt_q;
                  if (if_len_q != '0) begin
                     release_q     <= 1'b1;
                     release_cnt_q <= if_len_q;
                     ptr_q         <= ptr_d;
                  end
                  state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign agen_start               = start_q;
   assign agen_reset_filter        = reset_filter_q;
   assign agen_usage_stride_pos_ld = usage_ld_q;
   assign agen_stride_len          = stride_q;
   assign agen_filter_len          = filter_len_q;
   assign agen_if_start_pos        = ptr_q;
   assign out_valid                = out_valid_q;
   assign out_win_idx              = out_win_idx_q;
   assign if_release               = release_q;
   assign if_release_cnt           = release_cnt_q;
   assign job_done                 = job_done_q;
   assign job_windows              = job_windows_q;

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Self-checking bench for conv_row_scheduler: directed rows from the plan plus random
// traffic, all compared against a cycle-level reference model of the row protocol.
module tb_conv_row_scheduler;

   localparam int DEPTH  = 8;
   localparam int P_IDLE = 0, P_START = 1, P_RUN = 2, P_DRAIN = 3, P_REL = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_valid, cfg_ready;
   logic [7:0] cfg_stride, cfg_filter_len, cfg_if_len;
   logic       sw_abort;
   logic       agen_start, agen_reset_filter, agen_usage_stride_pos_ld;
   logic [7:0] agen_stride_len, agen_filter_len, agen_if_start_pos;
   logic       agen_done, agen_full_done, mac_psum_done;
   logic       agen_psum_done, agen_stall;
   logic       out_valid, out_ready;
   logic [7:0] out_win_idx;
   logic       if_release;
   logic [7:0] if_release_cnt;
   logic       job_done;
   logic [7:0] job_windows;

   always #5 clk = ~clk;

   conv_row_scheduler dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_stride(cfg_stride), .cfg_filter_len(cfg_filter_len), .cfg_if_len(cfg_if_len),
      .sw_abort(sw_abort),
      .agen_start(agen_start), .agen_reset_filter(agen_reset_filter),
      .agen_usage_stride_pos_ld(agen_usage_stride_pos_ld),
      .agen_stride_len(agen_stride_len), .agen_filter_len(agen_filter_len),
      .agen_if_start_pos(agen_if_start_pos),
      .agen_done(agen_done), .agen_full_done(agen_full_done), .mac_psum_done(mac_psum_done),
      .agen_psum_done(agen_psum_done), .agen_stall(agen_stall),
      .out_valid(out_valid), .out_ready(out_ready), .out_win_idx(out_win_idx),
      .if_release(if_release), .if_release_cnt(if_release_cnt),
      .job_done(job_done), .job_windows(job_windows)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: row phase, pending window, counters and the persistent IF pointer.
   int m_phase, m_idx, m_cnt, m_ptr, m_len, m_stride, m_flen, m_jw, m_relcnt;
   bit m_ov, m_start, m_rstf, m_rel, m_done;

   task automatic model_reset();
      m_phase = P_IDLE; m_idx = 0; m_cnt = 0; m_ptr = 0; m_len = 0;
      m_stride = 0; m_flen = 0; m_jw = 0; m_relcnt = 0;
      m_ov = 0; m_start = 0; m_rstf = 0; m_rel = 0; m_done = 0;
   endtask

   task automatic model_clock();
      bit ev;
      bit ov_before;
      ov_before = m_ov;
      ev = (m_phase == P_RUN) && agen_done && mac_psum_done && !(m_ov && !out_ready);
      m_start = 0; m_rstf = 0; m_rel = 0; m_done = 0;
      if (ev) begin
         m_ov = 1; m_idx = m_cnt; m_cnt = (m_cnt + 1) % 256;
      end else if (out_ready) begin
         m_ov = 0;
      end
      if (sw_abort && m_phase != P_IDLE) begin
         m_phase = P_IDLE; m_rstf = 1; m_ov = 0;
      end else begin
         case (m_phase)
            P_IDLE: if (cfg_valid) begin
               m_stride = cfg_stride; m_flen = cfg_filter_len; m_len = cfg_if_len;
               m_cnt = 0; m_start = 1; m_rstf = 1; m_phase = P_START;
            end
            P_START: m_phase = P_RUN;
            P_RUN:   if (agen_full_done) m_phase = P_DRAIN;
            P_DRAIN: if (!ov_before) m_phase = P_REL;
            default: begin
               m_done = 1; m_jw = m_cnt;
               if (m_len != 0) begin
                  m_rel = 1; m_relcnt = m_len; m_ptr = (m_ptr + m_len) % DEPTH;
               end
               m_phase = P_IDLE;
            end
         endcase
      end
   endtask

   // One clock: combinational checks before the edge, registered checks on the next negedge.
   task automatic step();
      #1;
      check("cfg_ready", cfg_ready, m_phase == P_IDLE);
      check("stall", agen_stall, (m_phase == P_RUN) && m_ov && !out_ready);
      check("psum_gate", agen_psum_done,
            (m_phase == P_RUN) && mac_psum_done && !(m_ov && !out_ready));
      model_clock();
      @(posedge clk);
      @(negedge clk);
      check("start", agen_start, m_start);
      check("reset_filter", agen_reset_filter, m_rstf);
      check("usage_ld", agen_usage_stride_pos_ld, m_phase == P_RUN);
      check("stride", agen_stride_len, m_stride);
      check("filter_len", agen_filter_len, m_flen);
      check("if_start_pos", agen_if_start_pos, m_ptr);
      check("out_valid", out_valid, m_ov);
      check("out_win_idx", out_win_idx, m_idx);
      check("if_release", if_release, m_rel);
      check("if_release_cnt", if_release_cnt, m_relcnt);
      check("job_done", job_done, m_done);
      check("job_windows", job_windows, m_jw);
   endtask

   task automatic idle_in();
      cfg_valid = 0; cfg_stride = 0; cfg_filter_len = 0; cfg_if_len = 0;
      sw_abort = 0; agen_done = 0; agen_full_done = 0; mac_psum_done = 0; out_ready = 1;
   endtask

   task automatic start_job(input int s, input int f, input int l);
      cfg_valid = 1; cfg_stride = 8'(s); cfg_filter_len = 8'(f); cfg_if_len = 8'(l);
      step();
      check("start_latency", agen_start, 1);
      cfg_valid = 0;
      step();
      check("run_latency", agen_usage_stride_pos_ld, 1);
   endtask

   task automatic one_event(input int exp_idx);
      agen_done = 1; mac_psum_done = 1; out_ready = 1;
      step();
      check("event_idx", out_win_idx, exp_idx);
      agen_done = 0; mac_psum_done = 0;
      step();
   endtask

   task automatic wait_done();
      for (int i = 0; i < 20; i++) begin
         if (job_done) break;
         step();
      end
      check("job_done_seen", job_done, 1);
   endtask

   task automatic finish_job();
      agen_full_done = 1;
      step();
      agen_full_done = 0;
      wait_done();
   endtask

   initial begin
      model_reset();
      idle_in();
      rst = 1;
      #3;
      check("rst_cfg_ready", cfg_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_ptr", agen_if_start_pos, 0);
      @(negedge clk);
      rst = 0;
      step();

      // Basic row: three windows, pointer advances to 5.
      start_job(1, 3, 5);
      for (int i = 0; i < 3; i++) one_event(i);
      finish_job();
      check("basic_windows", job_windows, 3);
      check("basic_ptr", agen_if_start_pos, 5);
      check("basic_rel", if_release, 1);
      check("basic_rel_cnt", if_release_cnt, 5);
      step();

      // Zero-length release keeps the pointer.
      start_job(1, 1, 0);
      one_event(0);
      finish_job();
      check("zero_rel", if_release, 0);
      check("zero_ptr", agen_if_start_pos, 5);
      step();

      // Pointer to 6, then 6 + 5 wraps to 3.
      start_job(1, 1, 1);
      finish_job();
      check("pre_wrap_ptr", agen_if_start_pos, 6);
      start_job(2, 2, 5);
      one_event(0);
      finish_job();
      check("wrap_ptr", agen_if_start_pos, 3);
      step();

      // Backpressure: held agen_done during a stalled window is counted once.
      start_job(2, 4, 3);
      agen_done = 1; mac_psum_done = 1; out_ready = 1;
      step();
      out_ready = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("bp_stall", agen_stall, 1);
         check("bp_psum", agen_psum_done, 0);
         step();
      end
      out_ready = 1;
      step();
      check("bp_idx", out_win_idx, 1);
      agen_done = 0; mac_psum_done = 0;
      step();
      finish_job();
      check("bp_windows", job_windows, 2);
      step();

      // Drain: full_done while the last window is held off for 3 cycles.
      start_job(1, 1, 2);
      agen_done = 1; mac_psum_done = 1; out_ready = 1;
      step();
      step();
      agen_done = 0; mac_psum_done = 0; out_ready = 0; agen_full_done = 1;
      step();
      agen_full_done = 0;
      for (int i = 0; i < 2; i++) begin
         step();
         check("drain_hold_done", job_done, 0);
         check("drain_hold_valid", out_valid, 1);
      end
      out_ready = 1;
      wait_done();
      check("drain_last_idx", out_win_idx, 1);
      check("drain_windows", job_windows, 2);
      step();

      // Abort after two windows, then a clean job restarts window numbering.
      start_job(3, 2, 4);
      one_event(0);
      one_event(1);
      sw_abort = 1;
      step();
      sw_abort = 0;
      check("abort_rstf", agen_reset_filter, 1);
      check("abort_idle", cfg_ready, 1);
      check("abort_no_done", job_done, 0);
      check("abort_ptr", agen_if_start_pos, m_ptr);
      start_job(1, 1, 1);
      one_event(0);
      finish_job();
      step();

      // Asynchronous reset mid-row.
      start_job(1, 2, 3);
      agen_done = 1; mac_psum_done = 1;
      step();
      #2 rst = 1;
      #1;
      check("arst_ready", cfg_ready, 1);
      check("arst_valid", out_valid, 0);
      check("arst_idx", out_win_idx, 0);
      check("arst_ld", agen_usage_stride_pos_ld, 0);
      check("arst_stride", agen_stride_len, 0);
      check("arst_ptr", agen_if_start_pos, 0);
      check("arst_stall", agen_stall, 0);
      model_reset();
      @(negedge clk);
      rst = 0;
      idle_in();
      step();

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         cfg_valid      = ($urandom % 4) == 0;
         cfg_stride     = 8'($urandom);
         cfg_filter_len = 8'($urandom);
         cfg_if_len     = ($urandom % 4 == 0) ? 8'd0 : 8'($urandom);
         agen_done      = 1'($urandom % 2);
         mac_psum_done  = ($urandom % 10) < 7;
         out_ready      = ($urandom % 10) < 6;
         agen_full_done = ($urandom % 12) == 0;
         sw_abort       = ($urandom % 40) == 0;
         step();
      end
      idle_in();
      for (int n = 0; n < 10; n++) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/conv_row_scheduler.md
# conv_row_scheduler

Sequencing controller for one PE's read address generator. It accepts a convolution-row job descriptor over a valid/ready handshake and configures and starts the address generator. It gates the generator's `psum_done` against a downstream partial-sum handshake, counts output windows, and on row completion advances the IF scratchpad start pointer and reports the freed entries to the IF write side. It sits between the PE-level job queue and the address generator / MAC pipeline.

## Interface
- `IF_ADDR_LEN`, default 8: IF scratchpad address width.
- `FILT_ADDR_LEN`, default 8: filter scratchpad address width.
- `IF_SCRATCH_DEPTH`, default 8: IF scratchpad entries. Need not be a power of two.
- `WIN_W`, default 8: window counter width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cfg_valid` in 1, `cfg_ready` out 1: job descriptor handshake.
- `cfg_stride` in IF_ADDR_LEN, `cfg_filter_len` in FILT_ADDR_LEN, `cfg_if_len` in IF_ADDR_LEN: stride, filter length, and IF entries consumed by the row.
- `sw_abort` in 1: synchronous abort.
- `agen_start` out 1, `agen_reset_filter` out 1, `agen_usage_stride_pos_ld` out 1: generator control.
- `agen_stride_len` out IF_ADDR_LEN, `agen_filter_len` out FILT_ADDR_LEN, `agen_if_start_pos` out IF_ADDR_LEN: registered configuration.
- `agen_done` in 1, `agen_full_done` in 1: generator status.
- `mac_psum_done` in 1: MAC accumulation complete.
- `agen_psum_done` out 1: gated psum_done to the generator.
- `agen_stall` out 1: stall_pipeline to the generator and MAC.
- `out_valid` out 1, `out_ready` in 1, `out_win_idx` out WIN_W: per-window psum handshake.
- `if_release` out 1, `if_release_cnt` out IF_ADDR_LEN: IF entries freed.
- `job_done` out 1, `job_windows` out WIN_W: row completion.

## Operation
- States: IDLE, START, RUN, DRAIN, RELEASE.
- IDLE: `cfg_ready`=1. On `cfg_valid`, latch stride, filter_len and if_len into the `agen_*` registers, clear `win_cnt`, then go to START.
- START: `agen_start`=1 and `agen_reset_filter`=1 for exactly one cycle, then go to RUN.
- RUN: `agen_usage_stride_pos_ld`=1. This signal is 0 in all other states.
- Window event = `agen_done & agen_psum_done`. `agen_done` may be held for several cycles; only events are counted.
- `agen_psum_done` = `mac_psum_done & ~(out_valid & ~out_ready)`. `agen_stall` = `out_valid & ~out_ready`. Both apply in RUN only and are 0 elsewhere.
- On an event, next cycle: `out_valid`=1, `out_win_idx`=`win_cnt`, and `win_cnt`+1 (wraps modulo 2^WIN_W).
- `out_valid` stays high until `out_ready`. If acceptance and a new event coincide, `out_valid` stays 1 and the index updates.
- RUN → DRAIN on `agen_full_done`.
- DRAIN waits until `out_valid`=0, then goes to RELEASE.
- RELEASE (one cycle) does all of the following, then goes to IDLE:
  - `agen_if_start_pos` ← (`agen_if_start_pos` + `cfg_if_len`) mod IF_SCRATCH_DEPTH, computed at IF_ADDR_LEN+1 bits.
  - `if_release`=1 with `if_release_cnt`=`cfg_if_len`. If `cfg_if_len`=0, no `if_release` pulse and the pointer is unchanged.
  - `job_done`=1 with `job_windows`=`win_cnt`.
- `sw_abort` in any non-IDLE state: next state is IDLE.
  - `agen_reset_filter`=1 for that cycle.
  - `out_valid` is cleared.
  - No `if_release`, no `job_done`, and `agen_if_start_pos` is unchanged.
  - `sw_abort` in IDLE has no effect.
- `agen_if_start_pos` persists across jobs and is cleared only by `rst`.

## Timing
- Reset values:
  - State = IDLE.
  - `cfg_ready`=1.
  - All `agen_*` registers = 0, including `agen_if_start_pos`.
  - All pulse outputs = 0.
  - `out_valid`=0, `out_win_idx`=0, `win_cnt`=0, `job_windows`=0, `if_release_cnt`=0.
- Latency:
  - Config accepted in cycle T → `agen_start` in T+1 → RUN from T+2.
  - Window event in T → `out_valid` in T+1.
  - `agen_full_done` in T with `out_valid`=0 → DRAIN in T+1 → RELEASE in T+2 → `cfg_ready` in T+3.
- All outputs are registered except `agen_psum_done`, `agen_stall` and `cfg_ready` (decoded from state).
- `agen_full_done` and a window event in the same cycle: the window is counted, and the state goes to DRAIN.
- `rst` mid-job: immediate return to IDLE, with every output at its reset value.

## Test plan
- **Basic row:** stride=1, filter_len=3, if_len=5; agen emits 3 events then full_done → out_win_idx 0,1,2; job_done with job_windows=3; agen_if_start_pos=5; if_release_cnt=5.
- **Backpressure:** out_ready=0 for 4 cycles after the first event → agen_stall=1 and agen_psum_done=0 for those 4 cycles even with mac_psum_done=1; agen_done held 4 cycles is counted once.
- **Wrap:** agen_if_start_pos=6, DEPTH=8, if_len=5 → new agen_if_start_pos=3.
- **Drain:** full_done arrives while out_valid=1 and out_ready=0 for 3 cycles → job_done only after acceptance; final out_win_idx is the last window.
- **Abort:** sw_abort in RUN after 2 events → agen_reset_filter pulse; IDLE next cycle; no job_done; agen_if_start_pos unchanged; a following job starts with out_win_idx=0.
- **Zero-length release and async reset:** if_len=0 → no if_release pulse and pointer unchanged. rst asserted mid-RUN → all outputs at reset values in the same cycle.
